// File: rtl/mult_initiator.sv
// Request/response front end for an iterative multiplier: latches an operand pair,
// pulses start, waits for done (with timeout), and holds the result until consumed.
module mult_initiator #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 start_o,
    input  logic                 done_i,
    output logic [WIDTH-1:0]     op_a_o,
    output logic [WIDTH-1:0]     op_b_o,
    input  logic [2*WIDTH-1:0]   product_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [2*WIDTH-1:0]   rsp_product_o,
    output logic                 rsp_err_o,
    output logic                 busy_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               err_q, err_d;

    // Saturating increment; the start cycle counts as one of the TIMEOUT cycles,
    // so timeout fires when the incremented count reaches TIMEOUT-1.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        prod_d  = prod_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_a_d = a_i;
                    op_b_d = b_i;
                    if (a_i == '0 || b_i == '0) begin
                        prod_d  = '0;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (done_i) begin
                    prod_d  = product_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_inc == CNT_MAX) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o   = (state_q == IDLE);
    assign start_o       = (state_q == ISSUE);
    assign rsp_valid_o   = (state_q == RESP);
    assign busy_o        = (state_q != IDLE);
    assign op_a_o        = op_a_q;
    assign op_b_o        = op_b_q;
    assign rsp_product_o = prod_q;
    assign rsp_err_o     = err_q;

endmodule

// File: tb/tb_mult_initiator.sv
// Directed bench for mult_initiator (WIDTH=8, TIMEOUT=16).
module tb_mult_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, start, done, rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0]  a, b, op_a, op_b;
    logic [15:0] product, rsp_product;
    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;

    mult_initiator #(.WIDTH(8), .TIMEOUT(16)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .a_i(a), .b_i(b), .start_o(start), .done_i(done),
        .op_a_o(op_a), .op_b_o(op_b), .product_i(product),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_product_o(rsp_product), .rsp_err_o(rsp_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start === 1'b1) start_cnt++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic expect_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        expect_bit({tag, " req_ready"}, req_ready, 1'b1);
        expect_bit({tag, " busy"}, busy, 1'b0);
        expect_bit({tag, " start"}, start, 1'b0);
        expect_bit({tag, " rsp_valid"}, rsp_valid, 1'b0);
    endtask

    task automatic test_reset();
        check_idle_outputs("reset");
        expect_val("reset op_a", {8'd0, op_a}, 16'd0);
        expect_val("reset op_b", {8'd0, op_b}, 16'd0);
        expect_val("reset product", rsp_product, 16'd0);
        expect_bit("reset err", rsp_err, 1'b0);
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_idle_outputs({tag, " post-handshake"});
    endtask

    task automatic test_basic();
        start_cnt = 0;
        req_valid = 1'b1; a = 8'd5; b = 8'd3;
        tick();
        req_valid = 1'b0;
        expect_bit("basic start", start, 1'b1);
        expect_bit("basic req_ready busy", req_ready, 1'b0);
        expect_val("basic op_a", {8'd0, op_a}, 16'd5);
        expect_val("basic op_b", {8'd0, op_b}, 16'd3);
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_bit("basic start low", start, 1'b0);
            expect_bit("basic no early rsp", rsp_valid, 1'b0);
        end
        done = 1'b1; product = 16'd15;
        tick();
        done = 1'b0; product = 16'd0;
        expect_bit("basic rsp_valid", rsp_valid, 1'b1);
        expect_val("basic product", rsp_product, 16'd15);
        expect_bit("basic err", rsp_err, 1'b0);
        expect_val("basic start pulses", 16'(start_cnt), 16'd1);
        handshake("basic");
    endtask

    task automatic test_zero_bypass(input logic [7:0] ta, input logic [7:0] tb);
        start_cnt = 0;
        req_valid = 1'b1; a = ta; b = tb; product = 16'hBEEF;
        tick();
        req_valid = 1'b0;
        expect_bit("zero rsp_valid", rsp_valid, 1'b1);
        expect_bit("zero start", start, 1'b0);
        expect_val("zero product", rsp_product, 16'd0);
        expect_bit("zero err", rsp_err, 1'b0);
        expect_val("zero op_b", {8'd0, op_b}, {8'd0, tb});
        handshake("zero");
        expect_val("zero start pulses", 16'(start_cnt), 16'd0);
        product = 16'd0;
    endtask

    // done_at: cycle offset after start_o at which done_i is driven; 0 means never.
    task automatic test_timeout(input int done_at, input logic [15:0] dprod,
                                input logic exp_err, input logic [15:0] exp_prod);
        req_valid = 1'b1; a = 8'd7; b = 8'd9; product = 16'd1234;
        tick();
        req_valid = 1'b0;
        expect_bit("to start", start, 1'b1);
        for (int k = 1; k < 16; k++) begin
            tick();
            if (k == 1 || k == 15) expect_bit("to no early rsp", rsp_valid, 1'b0);
            if (k == done_at) begin
                done = 1'b1; product = dprod;
            end
        end
        tick();
        done = 1'b0; product = 16'd0;
        expect_bit("to rsp_valid at +16", rsp_valid, 1'b1);
        expect_bit("to err", rsp_err, exp_err);
        expect_val("to product", rsp_product, exp_prod);
        handshake("to");
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; a = 8'd255; b = 8'd255;
        tick();
        req_valid = 1'b0;
        tick();
        done = 1'b1; product = 16'd65025;
        tick();
        done = 1'b0; product = 16'd7;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) done = 1'b1;
            if (k == 3) rsp_ready = 1'b1;
            expect_bit("bp rsp_valid held", rsp_valid, 1'b1);
            expect_val("bp product held", rsp_product, 16'd65025);
            expect_bit("bp err held", rsp_err, 1'b0);
            expect_val("bp op_a stable", {8'd0, op_a}, 16'd255);
            tick();
            done = 1'b0;
        end
        rsp_ready = 1'b0;
        check_idle_outputs("bp");
        product = 16'd0;
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1; a = 8'd3; b = 8'd4;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        expect_bit("rstmid busy before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rstmid async");
        expect_val("rstmid op_a", {8'd0, op_a}, 16'd0);
        tick();
        rst_n = 1'b1;
        done = 1'b1; product = 16'd12;
        tick();
        done = 1'b0; product = 16'd0;
        for (int k = 0; k < 3; k++) begin
            check_idle_outputs("rstmid after");
            expect_val("rstmid product", rsp_product, 16'd0);
            tick();
        end
    endtask

    task automatic test_done_in_idle();
        done = 1'b1; product = 16'd99;
        tick();
        done = 1'b0; product = 16'd0;
        check_idle_outputs("idle done");
        expect_val("idle done product", rsp_product, 16'd0);
        expect_bit("idle done err", rsp_err, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; done = 1'b0;
        a = '0; b = '0; product = '0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_zero_bypass(8'd0, 8'd200);
        test_zero_bypass(8'd9, 8'd0);
        test_timeout(0, 16'd0, 1'b1, 16'd0);
        test_backpressure();
        test_reset_mid_wait();
        test_done_in_idle();
        test_timeout(15, 16'd63, 1'b0, 16'd63);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_initiator.md
MULT_INITIATOR -- requirements
Module: mult_initiator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum cycles to wait for done_i before flagging an error.
REQ-003 SHALL have port clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid_i  input  1  operand pair valid.
REQ-006 SHALL have port req_ready_o  output  1  block can accept an operand pair.
REQ-007 SHALL have port a_i  input  WIDTH  multiplicand.
REQ-008 SHALL have port b_i  input  WIDTH  multiplier (loop count).
REQ-009 SHALL have port start_o  output  1  single-cycle start pulse to the multiplier controller.
REQ-010 SHALL have port done_i  input  1  multiplication-done pulse from the multiplier controller.
REQ-011 SHALL have port op_a_o  output  WIDTH  registered operand A driven to the multiplier datapath.
REQ-012 SHALL have port op_b_o  output  WIDTH  registered operand B driven to the multiplier datapath.
REQ-013 SHALL have port product_i  input  2*WIDTH  product from the multiplier datapath, valid in the done_i cycle.
REQ-014 SHALL have port rsp_valid_o  output  1  result valid.
REQ-015 SHALL have port rsp_ready_i  input  1  consumer accepts result.
REQ-016 SHALL have port rsp_product_o  output  2*WIDTH  captured product.
REQ-017 SHALL have port rsp_err_o  output  1  result is a timeout error; qualified by rsp_valid_o.
REQ-018 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; encoding is free.
REQ-020 IDLE: req_ready_o=1; on req_valid_i&&req_ready_o, SHALL register a_i/b_i into op_a_o/op_b_o.
REQ-021 On accept with a_i==0 or b_i==0, SHALL go directly to RESP with rsp_product_o=0 and rsp_err_o=0, and SHALL NOT assert start_o (zero-operand bypass).
REQ-022 On accept with both operands nonzero, SHALL go to ISSUE.
REQ-023 ISSUE: start_o=1 for exactly one cycle; wait counter cleared; next state WAIT.
REQ-024 WAIT: counter increments by 1 each cycle, saturating at TIMEOUT-1; start_o=0.
REQ-025 WAIT with done_i=1: capture product_i into rsp_product_o, set rsp_err_o=0, go to RESP.
REQ-026 WAIT with counter==TIMEOUT-1 and done_i=0: set rsp_product_o=0 and rsp_err_o=1, go to RESP.
REQ-027 If done_i and timeout occur in the same cycle, done_i SHALL win.
REQ-028 done_i outside WAIT SHALL be ignored, with no state or output change.
REQ-029 op_a_o/op_b_o SHALL remain stable from accept until leaving RESP.
REQ-030 RESP: rsp_valid_o=1; rsp_product_o and rsp_err_o SHALL be held stable until rsp_ready_i=1, then go to IDLE.
REQ-031 req_ready_o SHALL be 0 in ISSUE, WAIT and RESP; one transaction in flight, no request buffering.
REQ-032 Latency, nonzero operands: accept at cycle N, start_o at N+1, rsp_valid_o in the cycle after done_i sampled.
REQ-033 Latency, zero bypass: rsp_valid_o at N+1.
REQ-034 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-035 rst_n_in low SHALL immediately force state=IDLE, counter=0, op_a_o=0, op_b_o=0, rsp_product_o=0, rsp_err_o=0, start_o=0, rsp_valid_o=0, busy_o=0; req_ready_o=1 after reset.
REQ-036 Reset asserted mid-WAIT or mid-RESP SHALL discard the transaction; a later done_i SHALL be ignored per REQ-028.

Verification (WIDTH=8)
REQ-037 a=5, b=3 accepted; done_i with product_i=15 four cycles after start_o -> one start_o pulse, rsp_product_o=15, rsp_err_o=0.
REQ-038 a=0, b=200 accepted -> start_o never asserted, rsp_valid_o next cycle with product 0.
REQ-039 TIMEOUT=16, a=7, b=9, done_i never asserted -> rsp_err_o=1 and product 0, with rsp_valid_o 16 cycles after start_o.
REQ-040 a=255, b=255, product_i=65025, rsp_ready_i held low 3 cycles -> rsp_valid_o and data stable for 4 cycles; IDLE the cycle after the handshake.
REQ-041 rst_n_in pulsed low during WAIT, then done_i driven -> all outputs at reset values, no rsp_valid_o.
REQ-042 done_i pulsed in IDLE, and done_i coincident with the timeout cycle -> first ignored; second yields rsp_err_o=0 with product_i captured.
